dac_frame_scheduler: RTL
========================

# dac_frame_scheduler

Sample-rate scheduler for the two-channel PmodDA2 DAC path. Accepts 12-bit samples for channels A and B from upstream producers over valid/ready. On each sample tick it builds two 16-bit DAC121S101 frames and launches one serializer transfer. It sits between the sample sources (sine generator, DMA) and the SCLK/SYNCn/DIN serializer, and reports underrun and overrun statistics.

## Interface
Parameters:
- DATA_W, 12: sample width; fixed to the DAC resolution.
- RATE_DIV, 1000: Clk cycles per sample period; must be >= 2.

Ports:
- Clk  in  1  system clock; all logic on the rising edge.
- Rst  in  1  synchronous, active-high reset.
- En  in  1  scheduler enable.
- A_Valid  in  1  channel A sample valid.
- A_Data  in  DATA_W  channel A sample.
- A_Ready  out  1  channel A staging register empty.
- B_Valid  in  1  channel B sample valid.
- B_Data  in  DATA_W  channel B sample.
- B_Ready  out  1  channel B staging register empty.
- Pd_A  in  2  power-down mode for channel A; sampled at launch.
- Pd_B  in  2  power-down mode for channel B; sampled at launch.
- Ser_Start  out  1  one-cycle frame launch pulse to the serializer.
- Ser_WordA  out  16  channel A frame, {2'b00, Pd_A, sample}.
- Ser_WordB  out  16  channel B frame, {2'b00, Pd_B, sample}.
- Ser_Done  in  1  one-cycle pulse from the serializer when the frame is complete.
- Stat_Clr  in  1  clears all statistics counters.
- Und_A  out  16  channel A underrun count, saturating.
- Und_B  out  16  channel B underrun count, saturating.
- Ovr  out  16  overrun (skipped frame) count, saturating.

## Operation
- **Tick counter:** runs 0..RATE_DIV-1 while En=1. Tick is asserted in the cycle where the count equals RATE_DIV-1, then the count wraps to 0. When En=0, the count is held at 0 and no ticks occur.
- **Staging, per channel:** one-deep register. Ready = staging empty. A sample is accepted on Valid&&Ready; the staging register becomes full on the next edge.
- **FSM states:** IDLE, READY, BUSY.
  - IDLE: entered after reset or when En=0 with no frame in flight. Moves to READY when En=1.
  - READY + tick: launch.
  - BUSY: waits for Ser_Done. On Ser_Done, moves to READY, or to IDLE if En=0.
- **Launch, for each channel:**
  - If staging is full, the staged sample moves into the output word and staging is cleared.
  - If staging is empty, the previous sample is repeated (zero-order hold) and the channel's Und counter increments.
  - Pd_x is sampled at the same time.
  - Ser_Start pulses for one cycle and the FSM goes to BUSY.
- **Tick while BUSY:** the frame is skipped and Ovr increments. Staging and the output words are untouched.
- **Tick and Ser_Done in the same cycle:** Done wins, and the tick launches normally with no overrun.
- **Valid accepted in the same cycle as a tick:** the tick sees the staging register as empty. An underrun is counted, and the new sample is held for the next tick.
- **En deasserted mid-frame:** the in-flight frame completes (Ser_WordA/B held until Done), then the FSM goes to IDLE. Staged samples are retained.
- **Counters:** saturate at 16'hFFFF. Stat_Clr has priority over a same-cycle increment; the result is 0.

## Timing
- **Reset values:**
  - Ser_Start=0.
  - Ser_WordA=Ser_WordB=16'h0000.
  - A_Ready=B_Ready=1.
  - Und_A=Und_B=Ovr=0.
  - Tick count 0; FSM in IDLE.
- **Start-up:** first tick occurs RATE_DIV cycles after En rises, counting the first En=1 cycle as count 0.
- **Launch latency:** Ser_Start is registered and high in the cycle after the tick. Ser_WordA/B are valid in that same cycle and stable until the cycle after Ser_Done.
- **Sample latency:** a sample accepted at cycle t appears on Ser_Word at the first launch whose tick is at cycle t+1 or later.
- **Ready timing:** Ready deasserts the cycle after acceptance and reasserts the cycle after launch.
- **Reset mid-frame:** all state returns to reset values on the next edge and Ser_Start stays 0. The serializer is reset by the same Rst.

## Structure
- **Package dac_pkg:**
  - DAC_DATA_W=12 and DAC_WORD_W=16.
  - pd_mode_t enum: PD_NORMAL=2'b00, PD_1K=2'b01, PD_100K=2'b10, PD_HIZ=2'b11.
  - sched_state_t (IDLE/READY/BUSY).
  - Function make_dac_word(pd, data).
- **Sub-module dac_chan_stage:** staging register, Ready logic, hold register and saturating underrun counter. Instantiated once for A and once for B. The top level holds the tick counter, FSM and Ovr counter.

## Test plan
- **Basic launch:** RATE_DIV=8, En=1, A=12'hC93, B=12'h895 staged before the first tick, Pd=00 -> Ser_Start at cycle 8, Ser_WordA=16'h0C93, Ser_WordB=16'h0895; Und=0.
- **Underrun hold:** no new samples for the second tick, Done returned promptly -> second frame repeats 16'h0C93/16'h0895; Und_A=Und_B=1.
- **Overrun:** Ser_Done withheld for 20 cycles with RATE_DIV=8 -> two ticks while BUSY give Ovr=2; words unchanged; next launch after Done on the next tick.
- **Simultaneous events:**
  - A_Valid accepted on a tick cycle -> Und_A increments; the sample is sent on the following tick.
  - Done coincident with a tick -> launch, Ovr unchanged.
- **Power-down and saturation:** Pd_B=PD_HIZ -> Ser_WordB[13:12]=2'b11. Und_A forced to 16'hFFFF plus a further underrun -> stays 16'hFFFF. Stat_Clr -> 0.
- **Reset and enable:**
  - Rst asserted while BUSY -> next cycle all outputs at reset values.
  - En dropped mid-frame -> the frame completes, then no Ser_Start while En=0.

Source files
------------

// File: rtl/dac_pkg.sv
// Shared types, widths and helpers for the PmodDA2 frame scheduler.
package dac_pkg;

    localparam int DAC_DATA_W = 12;
    localparam int DAC_WORD_W = 16;
    localparam int STAT_W     = 16;

    localparam logic [STAT_W-1:0] STAT_MAX = '1;

    // DAC121S101 power-down control bits (frame bits 13:12).
    typedef enum logic [1:0] {
        PD_NORMAL = 2'b00,
        PD_1K     = 2'b01,
        PD_100K   = 2'b10,
        PD_HIZ    = 2'b11
    } pd_mode_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        READY = 2'b01,
        BUSY  = 2'b10
    } sched_state_t;

    // DAC121S101 frame: two don't-care zeros, power-down mode, sample.
    function automatic logic [DAC_WORD_W-1:0] make_dac_word(
        input logic [1:0]            pd,
        input logic [DAC_DATA_W-1:0] data
    );
        return {2'b00, pd, data};
    endfunction

    // Statistics counters stick at all-ones instead of wrapping.
    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] value);
        return (value == STAT_MAX) ? value : value + 1'b1;
    endfunction

endpackage

// File: rtl/dac_chan_stage.sv
// One DAC channel: one-deep staging register with ready, zero-order-hold
// output sample, latched power-down mode and saturating underrun counter.
module dac_chan_stage
    import dac_pkg::*;
(
    input  logic                  clk,
    input  logic                  srst,
    input  logic                  valid,
    input  logic [DAC_DATA_W-1:0] data,
    output logic                  ready,
    input  logic                  launch,
    input  logic [1:0]            pd,
    input  logic                  stat_clr,
    output logic [DAC_WORD_W-1:0] word,
    output logic [STAT_W-1:0]     und
);

    logic                  full_reg,  full_next;
    logic [DAC_DATA_W-1:0] stage_reg, stage_next;
    logic [DAC_DATA_W-1:0] hold_reg,  hold_next;
    logic [1:0]            pd_reg,    pd_next;
    logic [STAT_W-1:0]     und_reg,   und_next;
    logic                  accept;

    // A full stage refuses new data, so launch-clear and accept never collide.
    assign accept = valid && !full_reg;
    assign ready  = !full_reg;
    assign word   = make_dac_word(pd_reg, hold_reg);
    assign und    = und_reg;

    // Launch consumes the staged sample or repeats the held one (underrun).
    always_comb begin
        full_next  = full_reg;
        stage_next = stage_reg;
        hold_next  = hold_reg;
        pd_next    = pd_reg;
        und_next   = und_reg;
        if (launch) begin
            pd_next = pd;
            if (full_reg) begin
                hold_next = stage_reg;
                full_next = 1'b0;
            end else begin
                und_next = sat_inc(und_reg);
            end
        end
        // A sample arriving on the launch cycle is kept for the next tick.
        if (accept) begin
            full_next  = 1'b1;
            stage_next = data;
        end
        if (stat_clr) begin
            und_next = '0;
        end
    end

    // Channel state registers.
    always_ff @(posedge clk) begin
        if (srst) begin
            full_reg  <= 1'b0;
            stage_reg <= '0;
            hold_reg  <= '0;
            pd_reg    <= '0;
            und_reg   <= '0;
        end else begin
            full_reg  <= full_next;
            stage_reg <= stage_next;
            hold_reg  <= hold_next;
            pd_reg    <= pd_next;
            und_reg   <= und_next;
        end
    end

endmodule

// File: rtl/dac_frame_scheduler.sv
// Sample-rate scheduler for the two-channel PmodDA2: tick counter, launch
// FSM, overrun counter and the two channel staging stages.
module dac_frame_scheduler
    import dac_pkg::*;
#(
    parameter int DATA_W   = DAC_DATA_W,
    parameter int RATE_DIV = 1000
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  En,
    input  logic                  A_Valid,
    input  logic [DATA_W-1:0]     A_Data,
    output logic                  A_Ready,
    input  logic                  B_Valid,
    input  logic [DATA_W-1:0]     B_Data,
    output logic                  B_Ready,
    input  logic [1:0]            Pd_A,
    input  logic [1:0]            Pd_B,
    output logic                  Ser_Start,
    output logic [DAC_WORD_W-1:0] Ser_WordA,
    output logic [DAC_WORD_W-1:0] Ser_WordB,
    input  logic                  Ser_Done,
    input  logic                  Stat_Clr,
    output logic [STAT_W-1:0]     Und_A,
    output logic [STAT_W-1:0]     Und_B,
    output logic [STAT_W-1:0]     Ovr
);

    localparam int               NUM_CHAN = 2;
    localparam int               CNT_W    = $clog2(RATE_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RATE_DIV - 1);

    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic              tick;
    sched_state_t      state_reg, state_next;
    logic              launch;
    logic              ovr_inc;
    logic              ser_start_reg;
    logic [STAT_W-1:0] ovr_reg, ovr_next;

    logic                  chan_valid [NUM_CHAN];
    logic [DAC_DATA_W-1:0] chan_data  [NUM_CHAN];
    logic                  chan_ready [NUM_CHAN];
    logic [1:0]            chan_pd    [NUM_CHAN];
    logic [DAC_WORD_W-1:0] chan_word  [NUM_CHAN];
    logic [STAT_W-1:0]     chan_und   [NUM_CHAN];

    assign chan_valid[0] = A_Valid;
    assign chan_valid[1] = B_Valid;
    assign chan_data[0]  = A_Data;
    assign chan_data[1]  = B_Data;
    assign chan_pd[0]    = Pd_A;
    assign chan_pd[1]    = Pd_B;

    assign A_Ready   = chan_ready[0];
    assign B_Ready   = chan_ready[1];
    assign Ser_WordA = chan_word[0];
    assign Ser_WordB = chan_word[1];
    assign Und_A     = chan_und[0];
    assign Und_B     = chan_und[1];
    assign Ser_Start = ser_start_reg;
    assign Ovr       = ovr_reg;

    // Sample-period counter; parked at zero while disabled.
    assign tick = En && (cnt_reg == CNT_LAST);

    always_comb begin
        cnt_next = cnt_reg + 1'b1;
        if (!En || tick) begin
            cnt_next = '0;
        end
    end

    // Tick counter register.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    // FSM state register.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM next state; a Done coinciding with a tick frees the slot for that tick.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (En) begin
                    state_next = READY;
                end
            end
            READY: begin
                if (!En) begin
                    state_next = IDLE;
                end else if (tick) begin
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (Ser_Done) begin
                    if (tick) begin
                        state_next = BUSY;
                    end else if (!En) begin
                        state_next = IDLE;
                    end else begin
                        state_next = READY;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // FSM outputs: launch when the serializer is free, otherwise count a skip.
    always_comb begin
        launch  = 1'b0;
        ovr_inc = 1'b0;
        if (tick) begin
            case (state_reg)
                READY:   launch = 1'b1;
                BUSY: begin
                    launch  = Ser_Done;
                    ovr_inc = !Ser_Done;
                end
                default: launch = 1'b0;
            endcase
        end
    end

    // Overrun counter next value; clear beats increment.
    always_comb begin
        ovr_next = ovr_reg;
        if (Stat_Clr) begin
            ovr_next = '0;
        end else if (ovr_inc) begin
            ovr_next = sat_inc(ovr_reg);
        end
    end

    // Registered launch pulse and overrun counter.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            ser_start_reg <= 1'b0;
            ovr_reg       <= '0;
        end else begin
            ser_start_reg <= launch;
            ovr_reg       <= ovr_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CHAN; gi++) begin : g_chan
            dac_chan_stage u_stage (
                .clk      (Clk),
                .srst     (Rst),
                .valid    (chan_valid[gi]),
                .data     (chan_data[gi]),
                .ready    (chan_ready[gi]),
                .launch   (launch),
                .pd       (chan_pd[gi]),
                .stat_clr (Stat_Clr),
                .word     (chan_word[gi]),
                .und      (chan_und[gi])
            );
        end
    endgenerate

endmodule
